// File: rtl/ttc3_kdf_sequencer.sv
// ttc3_kdf_sequencer: round-robin owner of the KDF datapath. It gates the DUS onto the
// engine input only during a derivation and holds the derived key only until release or abort.
module ttc3_kdf_sequencer #(
  parameter int NUM_REQ     = 2,
  parameter int DUS_WIDTH   = 256,
  parameter int KEY_WIDTH   = 256,
  parameter int LABEL_WIDTH = 32,
  parameter int TIMEOUT     = 1000,
  parameter int HOLD_MAX    = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dus_valid,
  input  logic [DUS_WIDTH-1:0]           dus_value,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*LABEL_WIDTH-1:0] req_label,
  input  logic [NUM_REQ-1:0]             req_release,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           kdf_request,
  output logic [DUS_WIDTH-1:0]           kdf_dus,
  output logic [LABEL_WIDTH-1:0]         kdf_label,
  input  logic                           engine_done,
  input  logic [KEY_WIDTH-1:0]           engine_key,
  output logic [KEY_WIDTH-1:0]           derived_key,
  output logic                           kdf_done,
  output logic                           kdf_busy,
  output logic                           err,
  output logic [1:0]                     err_code
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_ZEROIZE = 2'd3
  } state_t;

  state_t                 state_r, state_n;
  logic [NUM_REQ-1:0]     grant_r, grant_n;
  logic [IW-1:0]          owner_r, owner_n;
  logic [IW-1:0]          last_r, last_n;
  logic [LABEL_WIDTH-1:0] label_r, label_n;
  logic [KEY_WIDTH-1:0]   key_r, key_n;
  logic [CW-1:0]          cnt_r, cnt_n;
  logic                   kreq_r, kreq_n;
  logic                   done_r, done_n;
  logic                   busy_r, busy_n;
  logic                   err_r, err_n;
  logic [1:0]             code_r, code_n;

  logic                   sel_found;
  logic [IW-1:0]          sel_idx;
  logic [NUM_REQ-1:0]     sel_grant;
  logic [LABEL_WIDTH-1:0] sel_label;
  logic                   owner_rel;

  assign owner_rel = |(req_release & grant_r);

  // Circular arbitration: lowest requester above last_r wins, else lowest overall.
  always_comb begin
    sel_found = |req_valid;
    sel_idx   = '0;
    sel_label = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      sel_idx = req_valid[j] ? IW'(j) : sel_idx;
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      sel_idx = (req_valid[j] && (IW'(j) > last_r)) ? IW'(j) : sel_idx;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      sel_grant[j] = (sel_idx == IW'(j));
      sel_label    = (sel_idx == IW'(j)) ? req_label[j*LABEL_WIDTH +: LABEL_WIDTH] : sel_label;
    end
  end

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    owner_n = owner_r;
    last_n  = last_r;
    label_n = label_r;
    key_n   = key_r;
    cnt_n   = cnt_r + CW'(1);
    kreq_n  = kreq_r;
    done_n  = done_r;
    err_n   = 1'b0;
    code_n  = code_r;
    case (state_r)
      ST_IDLE: begin
        cnt_n = '0;
        if (dus_valid && sel_found) begin
          state_n = ST_WAIT;
          grant_n = sel_grant;
          owner_n = sel_idx;
          label_n = sel_label;
          kreq_n  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // done takes priority over the final timeout cycle
        if (engine_done) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
          key_n   = engine_key;
          kreq_n  = 1'b0;
          done_n  = 1'b1;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_n = ST_ZEROIZE;
          cnt_n   = '0;
          kreq_n  = 1'b0;
          grant_n = '0;
          label_n = '0;
          err_n   = 1'b1;
          code_n  = 2'd1;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (owner_rel || (cnt_r == CW'(HOLD_MAX - 1))) begin
          state_n = ST_ZEROIZE;
          cnt_n   = '0;
          key_n   = '0;
          grant_n = '0;
          label_n = '0;
          done_n  = 1'b0;
          err_n   = !owner_rel;
          code_n  = owner_rel ? code_r : 2'd2;
        end else begin
          state_n = ST_HOLD;
        end
      end
      ST_ZEROIZE: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        last_n  = owner_r;
        key_n   = '0;
        grant_n = '0;
        label_n = '0;
        kreq_n  = 1'b0;
        done_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        key_n   = '0;
        grant_n = '0;
        label_n = '0;
        kreq_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_r <= '0;
      owner_r <= '0;
      last_r  <= IW'(NUM_REQ - 1);
      label_r <= '0;
      key_r   <= '0;
      cnt_r   <= '0;
      kreq_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      code_r  <= 2'd0;
    end else begin
      grant_r <= grant_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      label_r <= label_n;
      key_r   <= key_n;
      cnt_r   <= cnt_n;
      kreq_r  <= kreq_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
      err_r   <= err_n;
      code_r  <= code_n;
    end
  end

  assign grant       = grant_r;
  assign kdf_request = kreq_r;
  assign kdf_dus     = kreq_r ? dus_value : {DUS_WIDTH{1'b0}};
  assign kdf_label   = label_r;
  assign derived_key = key_r;
  assign kdf_done    = done_r;
  assign kdf_busy    = busy_r;
  assign err         = err_r;
  assign err_code    = code_r;

endmodule

// File: doc/ttc3_kdf_sequencer.md
# ttc3_kdf_sequencer

Controller that arbitrates the KDF datapath among NUM_REQ requesters inside the 3TC security boundary. It gates the Device Unique Secret onto the KDF input only while a derivation is in flight and holds the derived key for the granted requester only until release. It zeroizes the key on completion, hold expiry, engine timeout or reset. It sits between the command decoder's requester ports and the KDF engine, and drives the kdf_request/kdf_dus/derived_key/kdf_busy/kdf_done signals checked by the security assertions.

## Interface
- NUM_REQ, 2: number of requesters; round-robin arbitrated.
- DUS_WIDTH, 256: DUS width.
- KEY_WIDTH, 256: derived key width.
- LABEL_WIDTH, 32: per-requester derivation label width.
- TIMEOUT, 1000: maximum engine cycles in WAIT before abort.
- HOLD_MAX, 64: maximum cycles a key is held awaiting release.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- dus_valid  in  1  DUS programmed and locked.
- dus_value  in  DUS_WIDTH  DUS from locked storage.
- req_valid  in  NUM_REQ  level request per requester.
- req_label  in  NUM_REQ*LABEL_WIDTH  label of requester i at bits [i*LABEL_WIDTH +: LABEL_WIDTH].
- req_release  in  NUM_REQ  requester done with key.
- grant  out  NUM_REQ  one-hot owner of the current operation; 0 when idle.
- kdf_request  out  1  level; high throughout the engine run.
- kdf_dus  out  DUS_WIDTH  dus_value when kdf_request, else 0.
- kdf_label  out  LABEL_WIDTH  latched label of the granted requester; 0 when idle.
- engine_done  in  1  engine result valid, single-cycle pulse.
- engine_key  in  KEY_WIDTH  engine result.
- derived_key  out  KEY_WIDTH  held key; 0 except in HOLD.
- kdf_done  out  1  high in HOLD (key valid to owner).
- kdf_busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on abort.
- err_code  out  2  1 = engine timeout, 2 = hold expiry; holds last value until the next err or reset.

## Operation
- States: IDLE, WAIT, HOLD, ZEROIZE.
- IDLE: if dus_valid and any req_valid, select the first set req_valid after last_grant (circular). Register grant, kdf_label and kdf_request=1, then go to WAIT. With dus_valid=0, requests are never granted and remain pending.
- WAIT: cycle counter increments each cycle. If engine_done, latch engine_key into derived_key, drop kdf_request (kdf_dus to 0), and go to HOLD. Otherwise, when the counter reaches TIMEOUT-1, pulse err with code 1 and go to ZEROIZE.
- HOLD: kdf_done=1 and derived_key is valid. If req_release of the grant holder is high, go to ZEROIZE. If HOLD_MAX cycles elapse without release, pulse err with code 2 and go to ZEROIZE. req_release from non-owners is ignored.
- ZEROIZE (one cycle): derived_key=0, kdf_label=0, grant=0, kdf_done=0, update last_grant to the owner, then go to IDLE.
- Dropping req_valid mid-operation does not abort; the sequence completes normally, and an unreleased key expires via HOLD_MAX.
- engine_done outside WAIT is ignored and never loaded into derived_key.
- Counters are sized for max(TIMEOUT, HOLD_MAX) and cleared on every state entry.

## Timing
- Reset (any state, including mid-WAIT or mid-HOLD) takes effect next edge: state IDLE; all outputs 0 (derived_key, kdf_dus, kdf_label, grant, kdf_request, kdf_done, kdf_busy, err, err_code); last_grant points so that requester 0 wins first.
- Request to kdf_request: 1 cycle (req_valid sampled in IDLE, kdf_request high next cycle).
- engine_done at edge N: derived_key and kdf_done valid from N+1; kdf_request low from N+1.
- Release sampled at edge M: derived_key is 0 from M+1; kdf_busy low from M+2; next grant earliest at M+3.
- Timeout: err pulses the cycle after TIMEOUT WAIT cycles; derived_key remains 0 throughout.
- Simultaneous engine_done and final timeout cycle: done wins, no err.
- Simultaneous release and final HOLD_MAX cycle: release wins, no err.

## Test plan
- Reset then dus_valid=1, req_valid=2'b01, engine_done 5 cycles after kdf_request with key 0xA5..A5 -> grant=01, kdf_dus=dus_value only during WAIT, derived_key=0xA5..A5 for HOLD, release -> derived_key 0 next cycle.
- Both requesters asserting continuously for 4 operations -> grants alternate 01,10,01,10; no overlap of kdf_done between owners.
- dus_valid=0 with req_valid=2'b11 for 50 cycles -> grant=0, kdf_request=0, kdf_dus=0 throughout; dus_valid rising -> grant 01 next cycle.
- Engine never signals done, TIMEOUT=16 -> err pulse, err_code=1, derived_key never nonzero, return to IDLE and service the next request.
- No release, HOLD_MAX=8 -> err, err_code=2, derived_key 0 after 8 HOLD cycles; non-owner release during HOLD has no effect.
- Reset asserted mid-HOLD with key nonzero -> derived_key=0, grant=0, kdf_busy=0 on the next edge; a stray engine_done in IDLE does not change derived_key.
